spi_master_buffered: RTL and testbench

Parametrised buffered SPI master peripheral, next generation of the single-mode SPI block. Host accesses a 32-bit control register and a DEPTH-byte full-duplex transfer buffer over a simple wr/reg_sel/addr bus. Adds all four CPOL/CPHA modes, a programmable sclk divider, NCS selectable chip selects, a busy flag and write protection while busy. Each buffer byte is shifted out MSB first and overwritten in place by the byte received during the same transfer.

---
 rtl/spi_master_buffered.sv | 208 ++++++++++++++++++++
 tb/tb_spi_master_buffered.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_buffered.sv
// Buffered SPI master: DEPTH-byte full-duplex buffer overwritten in place, all four
// CPOL/CPHA modes, programmable sclk half-period and NCS active-low chip selects.
module spi_master_buffered #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned NCS   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr,
  input  logic           reg_sel,
  input  logic [N-1:0]   addr_i,
  input  logic [N-1:0]   in_i,
  output logic [N-1:0]   out_o,
  input  logic           miso,
  output logic           mosi,
  output logic           sclk,
  output logic [NCS-1:0] cs_o,
  output logic           tx_done_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_WRITEBACK,
    S_HOLD
  } state_e;

  state_e         state_q;
  logic           send_q, cpol_q, all1_q, all0_q, cpha_q;
  logic [8:0]     nte_q;
  logic [1:0]     cs_sel_q;
  logic [7:0]     div_q, cnt_q;
  logic [3:0]     hp_q;
  logic [AW:0]    idx_q, last_idx_d;
  logic [AW-1:0]  ld_idx_d;
  logic [7:0]     tx_q, rx_q, tx_byte_d;
  logic           sclk_q, mosi_q, done_q;
  logic [NCS-1:0] cs_q, cs_d;
  logic [7:0]     buf_q [DEPTH];

  logic           idle, busy, ctrl_we, buf_we_host, cnt_end;
  logic [24:0]    ctrl_rd;
  logic           unused_bits;

  assign idle        = (state_q == S_IDLE);
  assign busy        = !idle;
  assign ctrl_we     = wr && !reg_sel && idle;
  assign buf_we_host = wr && reg_sel && idle;
  assign cnt_end     = (cnt_q == div_q);
  assign unused_bits = ^{addr_i[N-1:AW], in_i[N-1:24]};

  assign ctrl_rd = {busy, div_q, cs_sel_q, cpha_q, nte_q, all0_q, all1_q, cpol_q, send_q};
  assign out_o   = reg_sel ? {{(N-8){1'b0}}, buf_q[addr_i[AW-1:0]]}
                           : {{(N-25){1'b0}}, ctrl_rd};

  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign cs_o      = cs_q;
  assign tx_done_o = done_q;

  // Next byte to load: index 0 when starting, index+1 at the end of each byte.
  always_comb begin
    ld_idx_d = '0;
    if (state_q == S_XFER) ld_idx_d = idx_q[AW-1:0] + AW'(1);
    if (all1_q)      tx_byte_d = 8'hFF;
    else if (all0_q) tx_byte_d = 8'h00;
    else             tx_byte_d = buf_q[ld_idx_d];
  end

  always_comb begin
    if (32'(nte_q) >= DEPTH - 1) last_idx_d = IW'(DEPTH - 1);
    else                         last_idx_d = IW'(nte_q);
  end

  always_comb begin
    cs_d = '1;
    for (int unsigned i = 0; i < NCS; i++) begin
      if (32'(cs_sel_q) == i) cs_d[i] = 1'b0;
    end
  end

  // Buffer deliberately has no reset so bytes already written back survive one.
  always_ff @(posedge clk) begin
    if (state_q == S_WRITEBACK) buf_q[idx_q[AW-1:0]] <= rx_q;
    else if (buf_we_host)       buf_q[addr_i[AW-1:0]] <= in_i[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      send_q   <= 1'b0;
      cpol_q   <= 1'b0;
      all1_q   <= 1'b0;
      all0_q   <= 1'b0;
      cpha_q   <= 1'b0;
      nte_q    <= '0;
      cs_sel_q <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      hp_q     <= '0;
      idx_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_q     <= '1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ctrl_we) begin
        send_q   <= in_i[0];
        cpol_q   <= in_i[1];
        all1_q   <= in_i[2];
        all0_q   <= in_i[3];
        nte_q    <= in_i[12:4];
        cpha_q   <= in_i[13];
        cs_sel_q <= in_i[15:14];
        div_q    <= in_i[23:16];
      end
      case (state_q)
        S_IDLE: begin
          sclk_q <= cpol_q;
          cnt_q  <= '0;
          if (send_q) begin
            state_q <= S_SETUP;
            cs_q    <= cs_d;
            idx_q   <= '0;
            mosi_q  <= tx_byte_d[7];
            tx_q    <= {tx_byte_d[6:0], 1'b0};
          end
        end
        S_SETUP: begin
          if (cnt_end) begin
            state_q <= S_XFER;
            cnt_q   <= '0;
            hp_q    <= '0;
            sclk_q  <= ~cpol_q;
            if (!cpha_q) rx_q <= {rx_q[6:0], miso};
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        // Half 15 sits at the idle level; mosi already holds bit 7 on XFER entry,
        // so each mode needs only 7 shifts per byte.
        S_XFER: begin
          if (cnt_end) begin
            cnt_q <= '0;
            if (hp_q == 4'd15) begin
              state_q <= S_WRITEBACK;
              sclk_q  <= cpol_q;
              done_q  <= 1'b1;
              mosi_q  <= tx_byte_d[7];
              tx_q    <= {tx_byte_d[6:0], 1'b0};
            end else begin
              hp_q   <= hp_q + 4'd1;
              sclk_q <= ~sclk_q;
              if (!hp_q[0]) begin
                if (cpha_q) begin
                  rx_q <= {rx_q[6:0], miso};
                end else if (hp_q != 4'd14) begin
                  mosi_q <= tx_q[7];
                  tx_q   <= {tx_q[6:0], 1'b0};
                end
              end else begin
                if (!cpha_q) begin
                  rx_q <= {rx_q[6:0], miso};
                end else begin
                  mosi_q <= tx_q[7];
                  tx_q   <= {tx_q[6:0], 1'b0};
                end
              end
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_WRITEBACK: begin
          idx_q <= idx_q + IW'(1);
          cnt_q <= '0;
          if (idx_q == last_idx_d) begin
            state_q <= S_HOLD;
          end else begin
            state_q <= S_XFER;
            hp_q    <= '0;
            sclk_q  <= ~cpol_q;
            if (!cpha_q) rx_q <= {rx_q[6:0], miso};
          end
        end
        S_HOLD: begin
          if (cnt_end) begin
            state_q <= S_IDLE;
            cs_q    <= '1;
            send_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_buffered.sv
// Directed bench for spi_master_buffered: modes 0/3, forced-pattern transmit,
// busy write protection, byte-count clamp and asynchronous reset mid-transfer.
module tb_spi_master_buffered;
  localparam int unsigned N     = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned NCS   = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           wr = 1'b0;
  logic           reg_sel = 1'b0;
  logic [N-1:0]   addr_i = '0;
  logic [N-1:0]   in_i = '0;
  logic [N-1:0]   out_o;
  logic           miso;
  logic           mosi;
  logic           sclk;
  logic [NCS-1:0] cs_o;
  logic           tx_done_o;

  logic        loop_en = 1'b0;
  logic        miso_model = 1'b0;
  logic        slave_on = 1'b0;
  logic [23:0] slave_sr = '0;

  int          checks = 0;
  int          failures = 0;
  int          rise_cnt = 0;
  int          done_cnt = 0;
  int          cs_low = 0;
  int          cs1_low = 0;
  int          cs_fall = 0;
  logic [31:0] mosi_sr = '0;

  assign miso = loop_en ? mosi : miso_model;

  spi_master_buffered #(.N(N), .DEPTH(DEPTH), .NCS(NCS)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr        (wr),
    .reg_sel   (reg_sel),
    .addr_i    (addr_i),
    .in_i      (in_i),
    .out_o     (out_o),
    .miso      (miso),
    .mosi      (mosi),
    .sclk      (sclk),
    .cs_o      (cs_o),
    .tx_done_o (tx_done_o)
  );

  always #5 clk = ~clk;

  always @(posedge sclk) begin
    rise_cnt++;
    mosi_sr = {mosi_sr[30:0], mosi};
  end

  // Mode-3 slave: presents the next bit on each leading (falling) edge.
  always @(negedge sclk) begin
    if (slave_on) begin
      miso_model = slave_sr[23];
      slave_sr   = {slave_sr[22:0], 1'b0};
    end
  end

  always @(negedge cs_o[0]) cs_fall++;

  always @(negedge clk) begin
    if (tx_done_o) done_cnt++;
    if (!cs_o[0]) cs_low++;
    if (!cs_o[1]) cs1_low++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    rise_cnt = 0;
    done_cnt = 0;
    cs_low   = 0;
    cs1_low  = 0;
    cs_fall  = 0;
    mosi_sr  = '0;
  endtask

  task automatic bus_write(input logic sel, input int unsigned a, input logic [31:0] d);
    @(negedge clk);
    wr = 1'b1; reg_sel = sel; addr_i = a; in_i = d;
    @(negedge clk);
    wr = 1'b0; reg_sel = 1'b0;
  endtask

  task automatic buf_read(input int unsigned a, output logic [31:0] d);
    @(negedge clk);
    reg_sel = 1'b1; addr_i = a;
    #1 d = out_o;
    reg_sel = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit seen = 1'b0;
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_o[24]) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        check_eq({tag, "_send_clr"}, {31'd0, out_o[0]}, 32'd0);
        break;
      end
    end
    check_eq({tag, "_idle"}, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    bit got;

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_ctrl", out_o, 32'h0);
    check_eq("rst_cs", {30'd0, cs_o}, 32'h3);
    check_eq("rst_sclk", {31'd0, sclk}, 32'h0);
    check_eq("rst_mosi", {31'd0, mosi}, 32'h0);
    check_eq("rst_done", {31'd0, tx_done_o}, 32'h0);
    rst = 1'b0;

    // Mode 0 loopback, div=0, one byte
    bus_write(1'b1, 0, 32'hA5);
    loop_en = 1'b1;
    clear_mon();
    bus_write(1'b0, 0, 32'h0000_0001);
    wait_idle("m0", 100);
    check_eq("m0_rises", rise_cnt, 8);
    check_eq("m0_done", done_cnt, 1);
    check_eq("m0_cycles", cs_low, 19);
    check_eq("m0_cs1", cs1_low, 0);
    check_eq("m0_csfall", cs_fall, 1);
    check_eq("m0_mosi", {24'd0, mosi_sr[7:0]}, 32'hA5);
    buf_read(0, r);
    check_eq("m0_buf0", r, 32'hA5);

    // Mode 3, div=3, three bytes against a slave model
    loop_en = 1'b0;
    bus_write(1'b1, 0, 32'h01);
    bus_write(1'b1, 1, 32'h80);
    bus_write(1'b1, 2, 32'h3C);
    bus_write(1'b0, 0, 32'h0003_2022);
    repeat (3) @(negedge clk);
    check_eq("m3_sclk_rest", {31'd0, sclk}, 32'h1);
    slave_sr = 24'hF00FAA;
    slave_on = 1'b1;
    clear_mon();
    bus_write(1'b0, 0, 32'h0003_2023);
    wait_idle("m3", 400);
    slave_on = 1'b0;
    check_eq("m3_sclk_idle", {31'd0, sclk}, 32'h1);
    check_eq("m3_done", done_cnt, 3);
    check_eq("m3_cycles", cs_low, 203);
    check_eq("m3_csfall", cs_fall, 1);
    check_eq("m3_rises", rise_cnt, 24);
    check_eq("m3_mosi", {8'd0, mosi_sr[23:0]}, 32'h0001_803C);
    buf_read(0, r); check_eq("m3_buf0", r, 32'hF0);
    buf_read(1, r); check_eq("m3_buf1", r, 32'h0F);
    buf_read(2, r); check_eq("m3_buf2", r, 32'hAA);

    // all_1s and all_0s both set, two bytes, miso held low
    bus_write(1'b0, 0, 32'h0);
    bus_write(1'b1, 0, 32'h12);
    bus_write(1'b1, 1, 32'h34);
    miso_model = 1'b0;
    clear_mon();
    bus_write(1'b0, 0, 32'h0000_001D);
    wait_idle("ff", 200);
    check_eq("ff_rises", rise_cnt, 16);
    check_eq("ff_mosi", {16'd0, mosi_sr[15:0]}, 32'hFFFF);
    check_eq("ff_done", done_cnt, 2);
    check_eq("ff_cycles", cs_low, 36);
    buf_read(0, r); check_eq("ff_buf0", r, 32'h00);
    buf_read(1, r); check_eq("ff_buf1", r, 32'h00);

    // Writes while busy are dropped
    bus_write(1'b0, 0, 32'h0);
    bus_write(1'b1, 0, 32'h3C);
    loop_en = 1'b1;
    clear_mon();
    bus_write(1'b0, 0, 32'h0001_0001);
    repeat (5) @(negedge clk);
    check_eq("bz_ctrl", out_o, 32'h0101_0001);
    bus_write(1'b0, 0, 32'h0);
    bus_write(1'b1, 0, 32'h55);
    wait_idle("bz", 200);
    check_eq("bz_ctrl_after", out_o, 32'h0001_0000);
    check_eq("bz_done", done_cnt, 1);
    check_eq("bz_cycles", cs_low, 37);
    check_eq("bz_mosi", {24'd0, mosi_sr[7:0]}, 32'h3C);
    buf_read(0, r); check_eq("bz_buf0", r, 32'h3C);

    // n_tx_end=511 clamps to 64 bytes
    bus_write(1'b0, 0, 32'h0);
    for (int i = 0; i < 64; i++) bus_write(1'b1, i, (i * 7 + 3) & 32'hFF);
    clear_mon();
    bus_write(1'b0, 0, 32'h0000_1FF1);
    wait_idle("cl", 2000);
    check_eq("cl_done", done_cnt, 64);
    check_eq("cl_cycles", cs_low, 1090);
    check_eq("cl_rises", rise_cnt, 512);
    buf_read(0, r);  check_eq("cl_buf0", r, 32'h03);
    buf_read(63, r); check_eq("cl_buf63", r, 32'hBC);

    // Reset asserted mid-XFER of the second byte (cpol=1, div=3)
    bus_write(1'b0, 0, 32'h0);
    bus_write(1'b1, 0, 32'h11);
    bus_write(1'b1, 1, 32'h22);
    loop_en = 1'b0;
    miso_model = 1'b1;
    clear_mon();
    bus_write(1'b0, 0, 32'h0003_0013);
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_cnt >= 1) begin
        got = 1'b1;
        break;
      end
    end
    check_eq("rs_first_done", {31'd0, got}, 32'd1);
    repeat (22) @(negedge clk);
    check_eq("rs_pre_ctrl", out_o, 32'h0103_0013);
    check_eq("rs_pre_sclk", {31'd0, sclk}, 32'h1);
    rst = 1'b1;
    #1;
    check_eq("rs_cs", {30'd0, cs_o}, 32'h3);
    check_eq("rs_sclk", {31'd0, sclk}, 32'h0);
    check_eq("rs_done", {31'd0, tx_done_o}, 32'h0);
    check_eq("rs_mosi", {31'd0, mosi}, 32'h0);
    check_eq("rs_ctrl", out_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    buf_read(0, r); check_eq("rs_buf0", r, 32'hFF);
    buf_read(1, r); check_eq("rs_buf1", r, 32'h22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
